// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, opcode width and reset defaults.
package cpu_pkg;

  typedef enum logic {
    S_REQ,
    S_VALID
  } fetch_state_t;

  localparam int OP_W                = 5;
  localparam int DEFAULT_INSTR_BYTES = 2;
  localparam int DEFAULT_RESET_PC    = 0;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch stage and memory.
interface fetch_unit_if #(
  parameter int n = 16
);
  logic         req;
  logic [n-1:0] addr;
  logic         ack;
  logic [n-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection: jump target beats branch target, else sequential increment.
module pc_next #(
  parameter int n           = 16,
  parameter int INSTR_BYTES = cpu_pkg::DEFAULT_INSTR_BYTES
) (
  input  logic [n-1:0] pc,
  input  logic         jump,
  input  logic [n-1:0] jtarget,
  input  logic         pcsrc,
  input  logic [n-1:0] btarget,
  output logic [n-1:0] pcplus,
  output logic [n-1:0] next_pc
);

  // Increment wraps silently at the top of the address space.
  assign pcplus = pc + n'(INSTR_BYTES);

  always_comb begin
    next_pc = pcplus;
    if (jump)
      next_pc = jtarget;
    else if (pcsrc)
      next_pc = btarget;
  end

endmodule

// File: rtl/fetch_unit.sv
// Multicycle instruction fetch: owns the PC, one outstanding memory request,
// instruction register and retired-instruction counter.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int           n           = 16,
  parameter logic [n-1:0] RESET_PC    = n'(DEFAULT_RESET_PC),
  parameter int           INSTR_BYTES = DEFAULT_INSTR_BYTES,
  parameter int           CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  fetch_unit_if.master      imem,
  input  logic              stall,
  input  logic              jump,
  input  logic [n-1:0]      jtarget,
  input  logic              pcsrc,
  input  logic [n-1:0]      btarget,
  output logic [n-1:0]      instr,
  output logic [OP_W-1:0]   op,
  output logic              instr_valid,
  output logic [n-1:0]      pc,
  output logic [n-1:0]      pcplus,
  output logic [CNT_W-1:0]  icount
);

  fetch_state_t     state_reg;
  logic [n-1:0]     pc_reg;
  logic [n-1:0]     instr_reg;
  logic [CNT_W-1:0] icount_reg;
  logic [n-1:0]     next_pc;

  pc_next #(
    .n           (n),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_pc_next (
    .pc      (pc_reg),
    .jump    (jump),
    .jtarget (jtarget),
    .pcsrc   (pcsrc),
    .btarget (btarget),
    .pcplus  (pcplus),
    .next_pc (next_pc)
  );

  // Redirect inputs only matter at the retire point (S_VALID, not stalled).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_REQ;
      pc_reg     <= RESET_PC;
      instr_reg  <= '0;
      icount_reg <= '0;
    end else begin
      case (state_reg)
        S_REQ: begin
          if (imem.ack) begin
            instr_reg <= imem.rdata;
            state_reg <= S_VALID;
          end
        end
        S_VALID: begin
          if (!stall) begin
            pc_reg     <= next_pc;
            icount_reg <= icount_reg + CNT_W'(1);
            state_reg  <= S_REQ;
          end
        end
        default: state_reg <= S_REQ;
      endcase
    end
  end

  assign imem.req    = (state_reg == S_REQ);
  assign imem.addr   = pc_reg;
  assign instr_valid = (state_reg == S_VALID);
  assign instr       = instr_reg;
  assign op          = instr_reg[n-1 -: OP_W];
  assign pc          = pc_reg;
  assign icount      = icount_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, jump, pcsrc;
  logic [15:0] jtarget, btarget;
  logic [15:0] instr, pc, pcplus;
  logic [4:0]  op;
  logic        instr_valid;
  logic [31:0] icount;

  int tests = 0;
  int fails = 0;

  fetch_unit_if #(.n(16)) imem_bus ();

  fetch_unit #(
    .n           (16),
    .RESET_PC    (16'h0000),
    .INSTR_BYTES (2),
    .CNT_W       (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem_bus),
    .stall       (stall),
    .jump        (jump),
    .jtarget     (jtarget),
    .pcsrc       (pcsrc),
    .btarget     (btarget),
    .instr       (instr),
    .op          (op),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pcplus      (pcplus),
    .icount      (icount)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    #1;
    tests++; if (pc !== 16'h0000) begin fails++; $display("FAIL reset_pc got %h want 0000", pc); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    tests++; if (imem_bus.req !== 1'b1) begin fails++; $display("FAIL reset_req got %b want 1", imem_bus.req); end
    tests++; if (icount !== 32'd0) begin fails++; $display("FAIL reset_icount got %0d want 0", icount); end
    tests++; if (op !== 5'd0) begin fails++; $display("FAIL reset_op got %b want 00000", op); end
    tests++; if (pcplus !== 16'h0002) begin fails++; $display("FAIL reset_pcplus got %h want 0002", pcplus); end
    $display("[TB] reset: pc=%h valid=%b req=%b icount=%0d", pc, instr_valid, imem_bus.req, icount);
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_sequential;
    logic [15:0] exp_pc;
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = 16'h0801;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 16'(2 * i);
      tests++; if (imem_bus.addr !== exp_pc) begin fails++; $display("FAIL seq_addr[%0d] got %h want %h", i, imem_bus.addr, exp_pc); end
      tick;
      tests++; if (instr_valid !== 1'b1 || op !== 5'b00001) begin fails++; $display("FAIL seq_valid_op[%0d] got %b/%b want 1/00001", i, instr_valid, op); end
      tests++; if (imem_bus.req !== 1'b0) begin fails++; $display("FAIL seq_req_low[%0d] got %b want 0", i, imem_bus.req); end
      tick;
      $display("[TB] seq fetch %0d: pc=%h icount=%0d", i, pc, icount);
    end
    tests++; if (icount !== 32'd3) begin fails++; $display("FAIL seq_icount got %0d want 3", icount); end
    tests++; if (pc !== 16'h0006) begin fails++; $display("FAIL seq_pc got %h want 0006", pc); end
  endtask

  task automatic test_wait_states;
    imem_bus.ack   = 1'b0;
    imem_bus.rdata = 16'hA5A3;
    for (int i = 0; i < 3; i++) begin
      tick;
      tests++; if (imem_bus.addr !== 16'h0006 || instr_valid !== 1'b0 || imem_bus.req !== 1'b1) begin
        fails++; $display("FAIL wait[%0d] got addr=%h valid=%b req=%b want 0006/0/1", i, imem_bus.addr, instr_valid, imem_bus.req); end
      tests++; if (instr !== 16'h0801) begin fails++; $display("FAIL wait_instr[%0d] got %h want 0801", i, instr); end
    end
    imem_bus.ack = 1'b1;
    tick;
    imem_bus.ack = 1'b0;
    tests++; if (instr !== 16'hA5A3 || instr_valid !== 1'b1) begin fails++; $display("FAIL wait_capture got %h/%b want a5a3/1", instr, instr_valid); end
    tests++; if (op !== 5'b10100) begin fails++; $display("FAIL wait_op got %b want 10100", op); end
    $display("[TB] wait states: captured instr=%h op=%b", instr, op);
  endtask

  task automatic test_stall;
    stall   = 1'b1;
    jump    = 1'b1;
    jtarget = 16'h0040;
    for (int i = 0; i < 4; i++) begin
      tick;
      tests++; if (instr !== 16'hA5A3 || pc !== 16'h0006 || icount !== 32'd3 || instr_valid !== 1'b1) begin
        fails++; $display("FAIL stall_hold[%0d] got instr=%h pc=%h icount=%0d valid=%b", i, instr, pc, icount, instr_valid); end
    end
    stall = 1'b0;
    jump  = 1'b0;
    tick;
    tests++; if (pc !== 16'h0008 || icount !== 32'd4 || imem_bus.req !== 1'b1) begin
      fails++; $display("FAIL stall_release got pc=%h icount=%0d req=%b want 0008/4/1", pc, icount, imem_bus.req); end
    $display("[TB] stall released: pc=%h icount=%0d", pc, icount);
  endtask

  task automatic test_redirect;
    // Redirects in S_REQ must be ignored.
    jump = 1'b1; jtarget = 16'h0040; pcsrc = 1'b1; btarget = 16'h0080;
    tick;
    tests++; if (pc !== 16'h0008) begin fails++; $display("FAIL redirect_in_req got %h want 0008", pc); end
    imem_bus.ack = 1'b1; imem_bus.rdata = 16'h1234;
    tick;
    tick;
    tests++; if (imem_bus.addr !== 16'h0040) begin fails++; $display("FAIL jump_priority got %h want 0040", imem_bus.addr); end
    $display("[TB] jump+pcsrc: next addr=%h", imem_bus.addr);
    jump = 1'b0;
    tick;
    tick;
    tests++; if (imem_bus.addr !== 16'h0080) begin fails++; $display("FAIL branch_only got %h want 0080", imem_bus.addr); end
    tests++; if (icount !== 32'd6) begin fails++; $display("FAIL redirect_icount got %0d want 6", icount); end
    $display("[TB] pcsrc only: next addr=%h icount=%0d", imem_bus.addr, icount);
    pcsrc = 1'b0;
  endtask

  task automatic test_wrap;
    jump = 1'b1; jtarget = 16'hFFFE;
    tick;
    tick;
    jump = 1'b0;
    tests++; if (pc !== 16'hFFFE || pcplus !== 16'h0000) begin fails++; $display("FAIL wrap_pcplus got pc=%h pcplus=%h want fffe/0000", pc, pcplus); end
    tick;
    tick;
    tests++; if (pc !== 16'h0000 || icount !== 32'd8) begin fails++; $display("FAIL wrap_next got pc=%h icount=%0d want 0000/8", pc, icount); end
    $display("[TB] wrap: pc=%h icount=%0d", pc, icount);
    imem_bus.ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; jump = 1'b0; pcsrc = 1'b0;
    jtarget = '0; btarget = '0;
    imem_bus.ack = 1'b0; imem_bus.rdata = '0;
    test_reset;
    test_sequential;
    test_wait_states;
    test_stall;
    test_redirect;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the CPU controller.
- Owns the PC and handshakes with instruction memory (req/ack).
- Latches the fetched word into an instruction register and presents `op` and `instr_valid` to the controller/datapath.
- Applies next-PC selection from `jump` / `pcsrc` fed back by the controller and datapath.
- Multicycle: at most one fetch in flight.

Parameters:
- n, 16, datapath / instruction / address width in bits (instructions are n bits; op = instr[n-1:n-5]).
- RESET_PC, 0, PC value loaded on reset.
- INSTR_BYTES, 2, PC increment per sequential instruction (n/8).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  n  fetch address (= pc).
- imem_ack  in  1  memory returns valid imem_rdata this cycle.
- imem_rdata  in  n  fetched instruction word.
- stall  in  1  downstream not ready; hold current instruction.
- jump  in  1  controller jump decode for the current instruction.
- jtarget  in  n  jump target from datapath.
- pcsrc  in  1  taken branch (branch & zero) for the current instruction.
- btarget  in  n  branch target from datapath.
- instr  out  n  instruction register.
- op  out  5  instr[n-1:n-5], to controller.
- instr_valid  out  1  instr/op valid for the controller.
- pc  out  n  address of the current instruction.
- pcplus  out  n  pc + INSTR_BYTES (for link and branch-offset arithmetic).
- icount  out  CNT_W  retired instruction count.

Behaviour:
- Reset is async: pc = RESET_PC, state = S_REQ, instr = 0, icount = 0. Outputs then read instr_valid = 0, imem_req = 1, imem_addr = RESET_PC, op = 0.
- A reset mid-fetch abandons the outstanding request; any later ack from the old request is not distinguished and is accepted in S_REQ (the memory must drop its request on reset).
- States: S_REQ, S_VALID.
- S_REQ:
  - imem_req = 1 (decoded from state); instr_valid = 0.
  - On imem_ack: instr <= imem_rdata and go to S_VALID. An ack in the same cycle as the req is legal, so minimum latency is 1 cycle.
  - No ack: remain in S_REQ, pc stable.
  - jump, pcsrc and stall are ignored in S_REQ.
- S_VALID:
  - imem_req = 0; instr_valid = 1; imem_ack is ignored.
  - stall = 1: hold the state, pc and instr. Redirect inputs are ignored while stalled; they must be re-presented when stall drops.
  - stall = 0: the instruction retires, so icount += 1 and the state returns to S_REQ.
  - Next pc = jtarget if jump; else btarget if pcsrc; else pcplus. jump has priority when both are set.
- Throughput: at best 1 instruction per 2 cycles.
- pcplus = pc + INSTR_BYTES, modulo 2^n; wrap from the top address to 0 is silent.
- Targets are taken verbatim. Misaligned targets (low bit set when INSTR_BYTES = 2) are not corrected.
- icount wraps modulo 2^CNT_W.
- All state is registered on the rising clk edge. op, instr_valid, imem_req, imem_addr and pcplus are combinational from registers only, with no input-to-output combinational path.

Decomposition:
- Shared package cpu_pkg holds:
  - the fetch_state_t enum {S_REQ, S_VALID};
  - OP_W = 5;
  - INSTR_BYTES default;
  - RESET_PC default.
- Sub-module pc_next (combinational next-PC mux plus incrementer, parameterised by n). It is reused by the datapath's branch logic.

Test Plan:
- Reset: assert reset mid-cycle, no clk edge -> pc = 0, instr_valid = 0, imem_req = 1, icount = 0 immediately.
- Sequential fetch: ack in the same cycle as req, rdata 16'h0801 at pc 0, no stall -> instr_valid on cycle 2 with op = 5'b00001; pc sequence 0, 2, 4; icount = 3 after 6 cycles.
- Wait states: ack delayed 3 cycles -> imem_addr stable and instr_valid = 0 for 3 cycles; instr captured only on ack.
- Stall: stall = 1 for 4 cycles in S_VALID with jump = 1 -> instr, pc and icount held, no redirect; drop stall with jump = 0 -> sequential pc + 2.
- Redirect priority: jump = 1, jtarget = 16'h0040, pcsrc = 1, btarget = 16'h0080 -> next imem_addr = 16'h0040. pcsrc alone -> 16'h0080.
- Wrap: pc = 16'hFFFE, sequential -> next pc = 16'h0000, no error; pcplus at 16'hFFFE reads 16'h0000.
